// File: rtl/beta_exe_shu_if.sv
`default_nettype none
// ============================================================================
// Module   : beta_exe_shu_if
// Purpose  : Handshake/data bundle between the exe control unit (master) and
//            the multicycle shift unit (slave).
// Signals  : shu_en_i     start request, level, held until busy falls
//            shu_mode_i   00 NONE, 01 SLL, 10 SRL, 11 SRA
//            shu_opa_i    value to shift
//            shu_shamt_i  shift amount
//            shu_size_o   {|shamt[msb:1], shamt[0]} : 00 zero, 01 one, 1x multi
//            shu_busy_o   high while iterating
//            shu_done_o   one-cycle pulse when the iterative result is valid
//            shu_result_o shift result
// Revision : 1.0 - initial release
// ============================================================================
interface beta_exe_shu_if #(
  parameter int DataWidth = 32
);
  localparam int ShamtW = $clog2(DataWidth);

  logic                 shu_en_i;
  logic [1:0]           shu_mode_i;
  logic [DataWidth-1:0] shu_opa_i;
  logic [ShamtW-1:0]    shu_shamt_i;
  logic [1:0]           shu_size_o;
  logic                 shu_busy_o;
  logic                 shu_done_o;
  logic [DataWidth-1:0] shu_result_o;

  modport master (
    output shu_en_i, shu_mode_i, shu_opa_i, shu_shamt_i,
    input  shu_size_o, shu_busy_o, shu_done_o, shu_result_o
  );

  modport slave (
    input  shu_en_i, shu_mode_i, shu_opa_i, shu_shamt_i,
    output shu_size_o, shu_busy_o, shu_done_o, shu_result_o
  );
endinterface
`default_nettype wire

// File: rtl/beta_exe_shu.sv
`default_nettype none
// ============================================================================
// Module   : beta_exe_shu
// Purpose  : Exe-stage shift unit. Zero/one-bit shifts resolve combinationally;
//            longer shifts iterate ShiftStep bits per cycle in an accumulator.
// Ports    : clk_i   clock, rising edge
//            rstn_i  asynchronous active-low reset
//            shu     beta_exe_shu_if.slave (en/mode/opa/shamt in,
//                    size/busy/done/result out)
// Revision : 1.0 - initial release
// ============================================================================
module beta_exe_shu #(
  parameter int DataWidth = 32,
  parameter int ShiftStep = 1
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  beta_exe_shu_if.slave  shu
);

  localparam int ShamtW = $clog2(DataWidth);
  // One extra bit so a step of 8 is representable even when DataWidth is 8.
  localparam logic [ShamtW:0] STEP_MAX = ShiftStep[ShamtW:0];

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_SLL  = 2'b01;
  localparam logic [1:0] MODE_SRL  = 2'b10;
  localparam logic [1:0] MODE_SRA  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] acc_q, acc_d;
  logic [ShamtW-1:0]    cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 sign_q, sign_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [1:0]           size_w;
  logic                 start_w;
  logic [ShamtW-1:0]    step_w;
  logic [ShamtW-1:0]    rem_w;
  logic [DataWidth-1:0] fill_w;
  logic [DataWidth-1:0] acc_shift_w;
  logic [DataWidth-1:0] fast_w;

  assign size_w  = {|shu.shu_shamt_i[ShamtW-1:1], shu.shu_shamt_i[0]};
  assign start_w = (state_q == S_IDLE) && shu.shu_en_i &&
                   (shu.shu_mode_i != MODE_NONE) && size_w[1];

  // Last iteration may move fewer than ShiftStep bits.
  assign step_w = ({1'b0, cnt_q} < STEP_MAX) ? cnt_q : STEP_MAX[ShamtW-1:0];
  assign rem_w  = cnt_q - step_w;
  // Ones in the top step_w bit positions: vacated bits for a right shift.
  assign fill_w = ~({DataWidth{1'b1}} >> step_w);

  always_comb begin
    acc_shift_w = acc_q;
    case (mode_q)
      MODE_SLL: acc_shift_w = acc_q << step_w;
      MODE_SRL: acc_shift_w = acc_q >> step_w;
      MODE_SRA: acc_shift_w = (acc_q >> step_w) | (fill_w & {DataWidth{sign_q}});
      default:  acc_shift_w = acc_q;
    endcase
  end

  // Single-bit fast path straight from the operand.
  always_comb begin
    fast_w = shu.shu_opa_i;
    if (shu.shu_shamt_i[0]) begin
      case (shu.shu_mode_i)
        MODE_SLL: fast_w = {shu.shu_opa_i[DataWidth-2:0], 1'b0};
        MODE_SRL: fast_w = {1'b0, shu.shu_opa_i[DataWidth-1:1]};
        MODE_SRA: fast_w = {shu.shu_opa_i[DataWidth-1], shu.shu_opa_i[DataWidth-1:1]};
        default:  fast_w = shu.shu_opa_i;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          acc_d   = shu.shu_opa_i;
          cnt_d   = shu.shu_shamt_i;
          mode_d  = shu.shu_mode_i;
          sign_d  = shu.shu_opa_i[DataWidth-1];
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_shift_w;
        cnt_d = rem_w;
        if (rem_w == '0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        // Wait for the CU to drop its request so a held en cannot retrigger.
        if (!shu.shu_en_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_NONE;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign shu.shu_size_o   = size_w;
  assign shu.shu_busy_o   = busy_q;
  assign shu.shu_done_o   = done_q;
  assign shu.shu_result_o = size_w[1] ? acc_q : fast_w;

endmodule
`default_nettype wire

// File: tb/tb_beta_exe_shu.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_exe_shu
// Purpose  : Self-checking bench. Two shift units (ShiftStep 1 and 4) receive
//            identical stimulus; a behavioural model predicts size, busy,
//            done and result for each every cycle, and directed literal
//            expectations pin latency and final values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beta_exe_shu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [1:0]  mode;
  logic [31:0] opa;
  logic [4:0]  shamt;

  always #5 clk = ~clk;

  beta_exe_shu_if #(.DataWidth(32)) if1 ();
  beta_exe_shu_if #(.DataWidth(32)) if4 ();

  assign if1.shu_en_i    = en;
  assign if1.shu_mode_i  = mode;
  assign if1.shu_opa_i   = opa;
  assign if1.shu_shamt_i = shamt;
  assign if4.shu_en_i    = en;
  assign if4.shu_mode_i  = mode;
  assign if4.shu_opa_i   = opa;
  assign if4.shu_shamt_i = shamt;

  beta_exe_shu #(.DataWidth(32), .ShiftStep(1)) u_dut1 (
    .clk_i (clk),
    .rstn_i(rstn),
    .shu   (if1.slave)
  );

  beta_exe_shu #(.DataWidth(32), .ShiftStep(4)) u_dut4 (
    .clk_i (clk),
    .rstn_i(rstn),
    .shu   (if4.slave)
  );

  logic [1:0]  size_a [2];
  logic        busy_a [2];
  logic        done_a [2];
  logic [31:0] res_a  [2];
  assign size_a[0] = if1.shu_size_o;   assign size_a[1] = if4.shu_size_o;
  assign busy_a[0] = if1.shu_busy_o;   assign busy_a[1] = if4.shu_busy_o;
  assign done_a[0] = if1.shu_done_o;   assign done_a[1] = if4.shu_done_o;
  assign res_a[0]  = if1.shu_result_o; assign res_a[1]  = if4.shu_result_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] a, input int sh);
    case (m)
      2'b01:   return a << sh;
      2'b10:   return a >> sh;
      2'b11:   return 32'($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  int          steps [2] = '{1, 4};
  int          ph    [2];   // 0 idle, 1 shifting, 2 finished holding
  int          rem   [2];   // cycles of shifting still to go
  logic [31:0] fin   [2];
  logic [31:0] hold  [2];
  logic        exp_done [2];

  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        ph[i] <= 0; rem[i] <= 0; fin[i] <= '0; hold[i] <= '0; exp_done[i] <= 1'b0;
      end else begin
        exp_done[i] <= 1'b0;
        case (ph[i])
          0: if (en && mode != 2'b00 && shamt >= 5'd2) begin
               fin[i] <= ref_shift(mode, opa, int'(shamt));
               rem[i] <= (int'(shamt) + steps[i] - 1) / steps[i];
               ph[i]  <= 1;
             end
          1: begin
               rem[i] <= rem[i] - 1;
               if (rem[i] == 1) begin
                 ph[i] <= 2; exp_done[i] <= 1'b1; hold[i] <= fin[i];
               end
             end
          default: if (!en) ph[i] <= 0;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [1:0]  es;
      logic [31:0] er;
      es = (shamt >= 5'd2) ? {1'b1, shamt[0]} : {1'b0, shamt[0]};
      chk($sformatf("size_s%0d", steps[i]), {30'b0, size_a[i]}, {30'b0, es});
      chk($sformatf("busy_s%0d", steps[i]), {31'b0, busy_a[i]}, {31'b0, ph[i] == 1});
      chk($sformatf("done_s%0d", steps[i]), {31'b0, done_a[i]}, {31'b0, exp_done[i]});
      if (ph[i] != 1) begin
        if (shamt >= 5'd2)                     er = hold[i];
        else if (mode == 2'b00 || shamt == 0)  er = opa;
        else                                   er = ref_shift(mode, opa, 1);
        chk($sformatf("result_s%0d", steps[i]), res_a[i], er);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input logic [1:0] m, input logic [31:0] a, input logic [4:0] sh,
                        input int eb1, input int eb4, input logic [31:0] er);
    int b1 = 0, b4 = 0;
    bit d1 = 0, d4 = 0;
    @(negedge clk); #1;
    en = 1'b1; mode = m; opa = a; shamt = sh;
    for (int k = 0; k < 200 && !(d1 && d4); k++) begin
      @(negedge clk);
      if (busy_a[0]) b1++;
      if (busy_a[1]) b4++;
      if (done_a[0]) d1 = 1;
      if (done_a[1]) d4 = 1;
      if (k == 2) begin #1; opa = ~opa; end  // mid-run operand change must not matter
    end
    chk("done_seen", {30'b0, d1, d4}, 32'd3);
    chk("lat_s1", b1, eb1);
    chk("lat_s4", b4, eb4);
    chk("res_lit_s1", res_a[0], er);
    chk("res_lit_s4", res_a[1], er);
    repeat (3) @(negedge clk);             // en still held: no retrigger
    chk("held_busy", {30'b0, busy_a[0], busy_a[1]}, 32'd0);
    chk("held_res_s1", res_a[0], er);
    #1; en = 1'b0;
    @(negedge clk);
    chk("idle_res_s4", res_a[1], er);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; mode = 2'b00; opa = '0; shamt = 5'd5;
    repeat (2) @(negedge clk);
    chk("rst_busy", {30'b0, busy_a[0], busy_a[1]}, 32'd0);
    chk("rst_done", {30'b0, done_a[0], done_a[1]}, 32'd0);
    chk("rst_res", res_a[0], 32'h0);
    #1; rstn = 1'b1;

    run_op(2'b01, 32'h0000_0001, 5'd5,  5,  2, 32'h0000_0020);
    run_op(2'b11, 32'h8000_0000, 5'd31, 31, 8, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 5'd31, 31, 8, 32'h0000_0001);
    run_op(2'b01, 32'h0000_0001, 5'd7,  7,  2, 32'h0000_0080);
    run_op(2'b11, 32'hF000_0000, 5'd9,  9,  3, 32'hFFF8_0000);

    // Fast path with en held: busy never rises.
    @(negedge clk); #1;
    en = 1'b1; mode = 2'b10; opa = 32'hDEAD_BEEF; shamt = 5'd0;
    repeat (3) @(negedge clk);
    chk("fast0_size", {30'b0, size_a[0]}, 32'd0);
    chk("fast0_res", res_a[0], 32'hDEAD_BEEF);
    #1; shamt = 5'd1;
    repeat (3) @(negedge clk);
    chk("fast1_size", {30'b0, size_a[1]}, 32'd1);
    chk("fast1_res", res_a[1], 32'h6F56_DF77);
    chk("fast_busy", {30'b0, busy_a[0], busy_a[1]}, 32'd0);
    #1; en = 1'b0;

    // Reset in the middle of a 20-bit shift.
    begin
      int nb = 0;
      @(negedge clk); #1;
      en = 1'b1; mode = 2'b01; opa = 32'h0000_0001; shamt = 5'd20;
      for (int k = 0; k < 50 && nb < 3; k++) begin
        @(negedge clk);
        if (busy_a[0]) nb++;
      end
      chk("rst_mid_reached", nb, 3);
      #1; rstn = 1'b0;
      #1;
      chk("rst_mid_busy", {30'b0, busy_a[0], busy_a[1]}, 32'd0);
      chk("rst_mid_res", res_a[0], 32'h0);
      @(negedge clk); #1; en = 1'b0;
      @(negedge clk); #1; rstn = 1'b1;
    end
    run_op(2'b01, 32'h0000_0001, 5'd20, 20, 5, 32'h0010_0000);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
